sync_arith_arbiter_2: RTL and testbench

- Shares one sync_arith_unit_12 instance between two requesters.
- Each requester presents a command {arg_A, arg_B, op} over a valid/ready handshake.
- The arbiter grants round-robin, drives the unit's operand/op inputs, waits the unit's latency, captures result and status, and returns them on the granted requester's response channel.
- Sits between the two issuing clients and the arithmetic unit.

---
 rtl/sync_arith_pkg.sv | 26 ++
 rtl/sync_arith_arbiter_2_rr_arb_2.sv | 27 ++
 rtl/sync_arith_arbiter_2.sv | 166 ++++++++++++++++
 tb/tb_sync_arith_arbiter_2.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_arith_pkg.sv
// Shared types and constants for the arithmetic-unit arbiter.
// State encoding, op codes and status bit positions.
package sync_arith_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CAPTURE,
        RESP
    } arb_state_t;

    localparam logic [1:0] OP_KONW  = 2'b00;
    localparam logic [1:0] OP_PORO  = 2'b01;
    localparam logic [1:0] OP_USTAW = 2'b10;
    localparam logic [1:0] OP_PRZES = 2'b11;

    localparam int ST_ERROR = 3;
    localparam int ST_ODD0  = 2;
    localparam int ST_ZEROS = 1;
    localparam int ST_OVF   = 0;

    function automatic logic [1:0] onehot2(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sync_arith_arbiter_2_rr_arb_2.sv
// Two-way round-robin grant, purely combinational.
// The pointer only breaks ties when both requesters are valid.
module rr_arb_2
    import sync_arith_pkg::*;
(
    input  logic [1:0] i_valid,
    input  logic       i_ptr,
    output logic [1:0] o_grant,
    output logic       o_grant_id
);

    // pick the winner and its one-hot grant
    always_comb begin
        o_grant    = 2'b00;
        o_grant_id = 1'b0;
        unique case (i_valid)
            2'b01: o_grant_id = 1'b0;
            2'b10: o_grant_id = 1'b1;
            2'b11: o_grant_id = i_ptr;
            default: o_grant_id = 1'b0;
        endcase
        if (i_valid != 2'b00) begin
            o_grant = onehot2(o_grant_id);
        end
    end

endmodule

// File: rtl/sync_arith_arbiter_2.sv
// Shares one arithmetic unit between two requesters, round-robin.
// Optional error counter enabled by SYNC_ARITH_ARB_ERR_CNT_EN.
module sync_arith_arbiter_2
    import sync_arith_pkg::*;
#(
    parameter int BITS    = 32,
    parameter int ALU_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [1:0]        i_req_valid,
    output logic [1:0]        o_req_ready,
    input  logic [2*BITS-1:0] i_req_arg_A,
    input  logic [2*BITS-1:0] i_req_arg_B,
    input  logic [3:0]        i_req_op,
    output logic [1:0]        o_rsp_valid,
    input  logic [1:0]        i_rsp_ready,
    output logic [BITS-1:0]   o_rsp_result,
    output logic [3:0]        o_rsp_status,
    output logic [BITS-1:0]   o_alu_arg_A,
    output logic [BITS-1:0]   o_alu_arg_B,
    output logic [1:0]        o_alu_op,
    input  logic [BITS-1:0]   i_alu_result,
    input  logic [3:0]        i_alu_status,
    output logic              o_busy
`ifdef SYNC_ARITH_ARB_ERR_CNT_EN
   ,output logic [7:0]        o_err_cnt
`endif
);

    localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT);

    arb_state_t      state_q, state_d;
    logic            ptr_q, ptr_d;
    logic            gnt_q, gnt_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [BITS-1:0] a_q, a_d;
    logic [BITS-1:0] b_q, b_d;
    logic [1:0]      op_q, op_d;
    logic [BITS-1:0] res_q, res_d;
    logic [3:0]      st_q, st_d;

    logic [1:0]      arb_gnt;
    logic            arb_id;

    rr_arb_2 u_arb (
        .i_valid    (i_req_valid),
        .i_ptr      (ptr_q),
        .o_grant    (arb_gnt),
        .o_grant_id (arb_id)
    );

    // next-state, operand latch and result capture
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        st_d    = st_q;
        unique case (state_q)
            IDLE: begin
                if (arb_gnt != 2'b00) begin
                    a_d     = arb_id ? i_req_arg_A[2*BITS-1:BITS]
                                     : i_req_arg_A[BITS-1:0];
                    b_d     = arb_id ? i_req_arg_B[2*BITS-1:BITS]
                                     : i_req_arg_B[BITS-1:0];
                    op_d    = arb_id ? i_req_op[3:2] : i_req_op[1:0];
                    gnt_d   = arb_id;
                    cnt_d   = LAT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                res_d   = i_alu_result;
                st_d    = i_alu_status;
                state_d = RESP;
            end
            RESP: begin
                if (i_rsp_ready[gnt_q]) begin
                    ptr_d   = ~gnt_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            gnt_q   <= 1'b0;
            cnt_q   <= 4'd0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 2'b00;
            res_q   <= '0;
            st_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            st_q    <= st_d;
        end
    end

    // handshake outputs decoded from state
    always_comb begin
        o_req_ready = 2'b00;
        o_rsp_valid = 2'b00;
        if (state_q == IDLE) begin
            o_req_ready = arb_gnt;
        end
        if (state_q == RESP) begin
            o_rsp_valid = onehot2(gnt_q);
        end
    end

    assign o_busy       = (state_q != IDLE);
    assign o_alu_arg_A  = a_q;
    assign o_alu_arg_B  = b_q;
    assign o_alu_op     = op_q;
    assign o_rsp_result = res_q;
    assign o_rsp_status = st_q;

`ifdef SYNC_ARITH_ARB_ERR_CNT_EN
    logic [7:0] err_q, err_d;

    // count error responses, saturating
    always_comb begin
        err_d = err_q;
        if (state_q == CAPTURE && i_alu_status[ST_ERROR] &&
            err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
        end
    end

    // error counter register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            err_q <= 8'd0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err_cnt = err_q;
`endif

endmodule

// File: tb/tb_sync_arith_arbiter_2.sv
// Bench for sync_arith_arbiter_2 with ALU stubs (A+B, ERROR on op 11).
// Two instances: ALU_LAT=1 and ALU_LAT=8.
module tb_sync_arith_arbiter_2;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] res;
        logic [3:0]  st;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
    } cmd_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    exp_t sb[$];
    exp_t sb8[$];
    cmd_t q0[$];
    cmd_t q1[$];

    // instance with ALU_LAT = 1
    logic        rst;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [63:0] req_a, req_b;
    logic [3:0]  req_op;
    logic [31:0] rsp_result, alu_a, alu_b, alu_res;
    logic [3:0]  rsp_status, alu_st;
    logic [1:0]  alu_op;
    logic        busy;
    logic [35:0] stub1;

    // instance with ALU_LAT = 8
    logic        rst8;
    logic [1:0]  req_valid8, req_ready8, rsp_valid8, rsp_ready8;
    logic [63:0] req_a8, req_b8;
    logic [3:0]  req_op8;
    logic [31:0] rsp_result8, alu_a8, alu_b8, alu_res8;
    logic [3:0]  rsp_status8, alu_st8;
    logic [1:0]  alu_op8;
    logic        busy8;
    logic [35:0] pipe8 [8];

`ifdef SYNC_ARITH_ARB_ERR_CNT_EN
    logic [7:0] err_cnt, err_cnt8;
`endif

    sync_arith_arbiter_2 #(.BITS(32), .ALU_LAT(1)) u_dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_arg_A  (req_a),
        .i_req_arg_B  (req_b),
        .i_req_op     (req_op),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_result (rsp_result),
        .o_rsp_status (rsp_status),
        .o_alu_arg_A  (alu_a),
        .o_alu_arg_B  (alu_b),
        .o_alu_op     (alu_op),
        .i_alu_result (alu_res),
        .i_alu_status (alu_st),
        .o_busy       (busy)
`ifdef SYNC_ARITH_ARB_ERR_CNT_EN
       ,.o_err_cnt    (err_cnt)
`endif
    );

    sync_arith_arbiter_2 #(.BITS(32), .ALU_LAT(8)) u_dut8 (
        .i_clk        (clk),
        .i_reset      (rst8),
        .i_req_valid  (req_valid8),
        .o_req_ready  (req_ready8),
        .i_req_arg_A  (req_a8),
        .i_req_arg_B  (req_b8),
        .i_req_op     (req_op8),
        .o_rsp_valid  (rsp_valid8),
        .i_rsp_ready  (rsp_ready8),
        .o_rsp_result (rsp_result8),
        .o_rsp_status (rsp_status8),
        .o_alu_arg_A  (alu_a8),
        .o_alu_arg_B  (alu_b8),
        .o_alu_op     (alu_op8),
        .i_alu_result (alu_res8),
        .i_alu_status (alu_st8),
        .o_busy       (busy8)
`ifdef SYNC_ARITH_ARB_ERR_CNT_EN
       ,.o_err_cnt    (err_cnt8)
`endif
    );

    // ALU stub, one-cycle latency
    always_ff @(posedge clk) begin
        stub1 <= {(alu_op == 2'b11) ? 4'b1000 : 4'b0000, alu_a + alu_b};
    end
    assign {alu_st, alu_res} = stub1;

    // ALU stub, eight-cycle latency
    always_ff @(posedge clk) begin
        pipe8[0] <= {(alu_op8 == 2'b11) ? 4'b1000 : 4'b0000, alu_a8 + alu_b8};
        for (int i = 1; i < 8; i++) pipe8[i] <= pipe8[i-1];
    end
    assign {alu_st8, alu_res8} = pipe8[7];

    function automatic exp_t model(input logic [1:0] id, input logic [31:0] a,
                                   input logic [31:0] b, input logic [1:0] op);
        exp_t e;
        e.id  = id;
        e.res = a + b;
        e.st  = (op == 2'b11) ? 4'b1000 : 4'b0000;
        return e;
    endfunction

    function automatic cmd_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [1:0] op);
        cmd_t c;
        c.a  = a;
        c.b  = b;
        c.op = op;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic chk_rsp(input string tag, output exp_t e);
        if (sb.size() == 0) begin
            e = '0;
            chk({tag, "_unexpected"}, {62'd0, rsp_valid}, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_id"}, {62'd0, rsp_valid}, {62'd0, e.id});
            chk({tag, "_res"}, {32'd0, rsp_result}, {32'd0, e.res});
            chk({tag, "_st"}, {60'd0, rsp_status}, {60'd0, e.st});
        end
    endtask

    task automatic wait_rsp(input string tag, input int budget);
        int n;
        exp_t e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rsp_valid == 2'b00 && n < budget);
        chk_rsp(tag, e);
    endtask

    task automatic present();
        req_valid = {q1.size() != 0, q0.size() != 0};
        if (q0.size() != 0) begin
            req_a[31:0] = q0[0].a;
            req_b[31:0] = q0[0].b;
            req_op[1:0] = q0[0].op;
        end
        if (q1.size() != 0) begin
            req_a[63:32] = q1[0].a;
            req_b[63:32] = q1[0].b;
            req_op[3:2]  = q1[0].op;
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        logic [1:0] acc;
        exp_t e;
        n = 0;
        present();
        while ((q0.size() + q1.size() + sb.size()) != 0 && n < budget) begin
            @(negedge clk);
            acc = req_ready & req_valid;
            if ((rsp_valid & rsp_ready) != 2'b00) chk_rsp(tag, e);
            @(posedge clk);
            #1;
            if (acc[0]) q0.delete(0);
            if (acc[1]) q1.delete(0);
            present();
            n++;
        end
        chk({tag, "_pending"}, 64'(q0.size() + q1.size() + sb.size()), 64'd0);
    endtask

    task automatic reset1();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic cmd8(input string tag, input logic id, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] op);
        exp_t e;
        int n;
        e = model(id ? 2'b10 : 2'b01, a, b, op);
        sb8.push_back(e);
        if (id) begin
            req_a8[63:32] = a;
            req_b8[63:32] = b;
            req_op8[3:2]  = op;
        end else begin
            req_a8[31:0] = a;
            req_b8[31:0] = b;
            req_op8[1:0] = op;
        end
        req_valid8 = e.id;
        @(negedge clk);
        chk({tag, "_rdy"}, {62'd0, req_ready8}, {62'd0, e.id});
        @(posedge clk);
        #1;
        req_valid8 = 2'b00;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rsp_valid8 == 2'b00 && n < 20);
        chk({tag, "_lat"}, 64'(n), 64'd10);
        e = sb8.pop_front();
        chk({tag, "_id"}, {62'd0, rsp_valid8}, {62'd0, e.id});
        chk({tag, "_res"}, {32'd0, rsp_result8}, {32'd0, e.res});
        chk({tag, "_st"}, {60'd0, rsp_status8}, {60'd0, e.st});
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        logic [1:0] seen;

        rst        = 1'b1;
        rst8       = 1'b1;
        req_valid  = 2'b00;
        req_valid8 = 2'b00;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        req_a8     = '0;
        req_b8     = '0;
        req_op8    = '0;
        rsp_ready  = 2'b11;
        rsp_ready8 = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {req_ready, rsp_valid, rsp_status, alu_op, busy}, 0);
        chk("rst_data", {alu_a, alu_b}, 0);
        chk("rst_res", {32'd0, rsp_result}, 0);
`ifdef SYNC_ARITH_ARB_ERR_CNT_EN
        chk("rst_err", {56'd0, err_cnt}, 0);
`endif
        @(posedge clk);
        #1;
        rst  = 1'b0;
        rst8 = 1'b0;

        // single command, exact latency
        req_a[31:0] = 32'd5;
        req_b[31:0] = 32'd3;
        req_op[1:0] = 2'b01;
        req_valid   = 2'b01;
        sb.push_back(model(2'b01, 32'd5, 32'd3, 2'b01));
        @(negedge clk);
        chk("t1_ready", {62'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        chk("t1_alu", {alu_a, alu_b}, {32'd5, 32'd3});
        chk("t1_c1_valid", {62'd0, rsp_valid}, 0);
        @(negedge clk);
        chk("t1_c2_valid", {62'd0, rsp_valid}, 0);
        @(negedge clk);
        chk_rsp("t1", e);
        @(negedge clk);
        chk("t1_c4_valid", {62'd0, rsp_valid}, 0);

        // simultaneous requests, alternation
        reset1();
        q0.push_back(mk(32'd1, 32'd1, 2'b00));
        q0.push_back(mk(32'd100, 32'd1, 2'b10));
        q1.push_back(mk(32'd10, 32'd20, 2'b01));
        sb.push_back(model(2'b01, 32'd1, 32'd1, 2'b00));
        sb.push_back(model(2'b10, 32'd10, 32'd20, 2'b01));
        sb.push_back(model(2'b01, 32'd100, 32'd1, 2'b10));
        drain("t2", 40);

        // response backpressure
        rsp_ready   = 2'b00;
        req_a[31:0] = 32'd7;
        req_b[31:0] = 32'd8;
        req_op[1:0] = 2'b10;
        req_valid   = 2'b01;
        sb.push_back(model(2'b01, 32'd7, 32'd8, 2'b10));
        @(negedge clk);
        chk("t3_ready0", {62'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1;
        req_a[63:32] = 32'd4;
        req_b[63:32] = 32'd6;
        req_op[3:2]  = 2'b01;
        req_valid    = 2'b10;
        sb.push_back(model(2'b10, 32'd4, 32'd6, 2'b01));
        repeat (2) @(negedge clk);
        @(negedge clk);
        chk_rsp("t3_a", e);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            rsp_ready = (i >= 2) ? 2'b10 : 2'b00;
            @(negedge clk);
            chk("t3_hold_v", {62'd0, rsp_valid}, {62'd0, e.id});
            chk("t3_hold_r", {32'd0, rsp_result}, {32'd0, e.res});
            chk("t3_hold_rdy", {62'd0, req_ready}, 0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 2'b01;
        @(negedge clk);
        chk("t3_hs_v", {62'd0, rsp_valid}, {62'd0, e.id});
        @(posedge clk);
        #1;
        rsp_ready = 2'b11;
        @(negedge clk);
        chk("t3_ready1", {62'd0, req_ready}, 64'd2);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        wait_rsp("t3_b", 10);
        @(posedge clk);
        #1;

        // error-status commands
        reset1();
        for (int i = 0; i < 3; i++) q0.push_back(mk(32'(i), 32'd1, 2'b11));
        q1.push_back(mk(32'd40, 32'd2, 2'b01));
        sb.push_back(model(2'b01, 32'd0, 32'd1, 2'b11));
        sb.push_back(model(2'b10, 32'd40, 32'd2, 2'b01));
        sb.push_back(model(2'b01, 32'd1, 32'd1, 2'b11));
        sb.push_back(model(2'b01, 32'd2, 32'd1, 2'b11));
        drain("t5", 60);
`ifdef SYNC_ARITH_ARB_ERR_CNT_EN
        chk("t5_err_cnt", {56'd0, err_cnt}, 64'd3);
`endif

        // reset during WAIT, long latency
        req_a8[31:0] = 32'd9;
        req_b8[31:0] = 32'd9;
        req_op8[1:0] = 2'b00;
        req_valid8   = 2'b01;
        @(negedge clk);
        chk("t4_ready", {62'd0, req_ready8}, 64'd1);
        @(posedge clk);
        #1;
        req_valid8 = 2'b00;
        @(negedge clk);
        chk("t4_wait", {63'd0, busy8}, 64'd1);
        chk("t4_alu", {alu_a8, alu_b8}, {32'd9, 32'd9});
        @(posedge clk);
        #1;
        rst8 = 1'b1;
        @(posedge clk);
        #1;
        rst8 = 1'b0;
        @(negedge clk);
        chk("t4_ctrl", {rsp_valid8, req_ready8, rsp_status8, alu_op8, busy8}, 0);
        chk("t4_data", {alu_a8, alu_b8}, 0);
        chk("t4_res", {32'd0, rsp_result8}, 0);
        seen = 2'b00;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen |= rsp_valid8;
        end
        chk("t4_no_rsp", {62'd0, seen}, 0);
        @(posedge clk);
        #1;
        cmd8("t4_fresh", 1'b0, 32'd2, 32'd3, 2'b00);

        // long latency, signed pass-through
        cmd8("t6", 1'b1, 32'hFFFF_FFF9, 32'd7, 2'b01);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
